// File: rtl/tx_sample_serializer_pkg.sv
// Shared constants and FSM encoding for the UART sample serializer.
// Imported by the FIFO and the serializer top.
package tx_sample_serializer_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int BYTES_PER_SAMPLE   = DEFAULT_DATA_WIDTH / BYTE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ARM   = 2'd2,
        WAIT  = 2'd3
    } txState_t;

    function automatic int bytesPerSample(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/tx_sample_serializer_fifo.sv
// Synchronous sample FIFO with first-word fall-through read port.
// Pointers wrap naturally since DEPTH is a power of two.
module tx_sample_fifo
    import tx_sample_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      cnt;
    logic             doPush;
    logic             doPop;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign dout   = mem[rdPtr];
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            unique case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/tx_sample_serializer.sv
// Buffers wide filter samples and feeds them byte by byte to the UART
// transmitter, pacing each start strobe on the transmitter busy flag.
module tx_sample_serializer
    import tx_sample_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [DATA_WIDTH-1:0]         sample_data,
    output logic                          sample_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy,
    output logic                          idle
);

    localparam int NBYTES = bytesPerSample(DATA_WIDTH);
    localparam int CNT_W  = $clog2(NBYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    txState_t              state;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [CNT_W-1:0]      byteCnt;
    logic                  txStartR;
    logic                  overflowR;
    logic                  loadSample;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [DATA_WIDTH-1:0] fifoDout;

    tx_sample_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_valid),
        .din   (sample_data),
        .pop   (loadSample),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifo_count)
    );

    assign sample_ready = !fifoFull;
    assign overflow     = overflowR;
    assign tx_start     = txStartR;
    assign idle         = (state == IDLE) && fifoEmpty;
    assign tx_data      = (MSB_FIRST != 0) ? shiftReg[DATA_WIDTH-1 -: BYTE_W]
                                           : shiftReg[BYTE_W-1:0];
    assign shifted      = (MSB_FIRST != 0) ? (shiftReg << BYTE_W)
                                           : (shiftReg >> BYTE_W);

    // A new sample is taken only when the transmitter is free and the
    // current sample (if any) has no bytes left.
    always_comb begin
        loadSample = 1'b0;
        unique case (state)
            IDLE:    loadSample = !fifoEmpty && !tx_busy;
            WAIT:    loadSample = !fifoEmpty && !tx_busy && (byteCnt == '0);
            default: loadSample = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflowR <= 1'b0;
        end else if (sample_valid && fifoFull) begin
            overflowR <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            byteCnt  <= '0;
            txStartR <= 1'b0;
        end else begin
            txStartR <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (loadSample) begin
                        shiftReg <= fifoDout;
                        byteCnt  <= LAST_BYTE;
                        state    <= START;
                        txStartR <= 1'b1;
                    end
                end
                START: state <= ARM;
                // Blanking cycle: busy rises one cycle after the strobe.
                ARM:   state <= WAIT;
                WAIT: begin
                    if (!tx_busy) begin
                        if (byteCnt != '0) begin
                            shiftReg <= shifted;
                            byteCnt  <= byteCnt - 1'b1;
                            state    <= START;
                            txStartR <= 1'b1;
                        end else if (loadSample) begin
                            shiftReg <= fifoDout;
                            byteCnt  <= LAST_BYTE;
                            state    <= START;
                            txStartR <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sample_serializer.sv
// Directed bench for tx_sample_serializer: an MSB-first and an LSB-first
// instance share stimulus and a 10-cycle-busy transmitter model.
`timescale 1ns/1ps
module tb_tx_sample_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        holdBusy = 1'b0;
    logic        tx_busy;

    logic        sample_ready, overflow, tx_start, idle;
    logic [3:0]  fifo_count;
    logic [7:0]  tx_data;
    logic        lsbReady, lsbOverflow, lsbStart, lsbIdle;
    logic [3:0]  lsbCount;
    logic [7:0]  lsbData;

    int vecs  = 0;
    int fails = 0;
    int cycle = 0;
    int busyLeft;

    logic [7:0] msbQ[$];
    logic [7:0] lsbQ[$];
    int         strobeCyc[$];
    int         cntAtStrobe[$];
    logic       prevStart = 1'b0;

    always #5 clk = ~clk;

    tx_sample_serializer #(
        .DATA_WIDTH (16), .FIFO_DEPTH (8), .MSB_FIRST (1)
    ) dut (
        .clk (clk), .rst (rst),
        .sample_valid (sample_valid), .sample_data (sample_data),
        .sample_ready (sample_ready), .overflow (overflow),
        .fifo_count (fifo_count), .tx_start (tx_start),
        .tx_data (tx_data), .tx_busy (tx_busy), .idle (idle)
    );

    tx_sample_serializer #(
        .DATA_WIDTH (16), .FIFO_DEPTH (8), .MSB_FIRST (0)
    ) dutLsb (
        .clk (clk), .rst (rst),
        .sample_valid (sample_valid), .sample_data (sample_data),
        .sample_ready (lsbReady), .overflow (lsbOverflow),
        .fifo_count (lsbCount), .tx_start (lsbStart),
        .tx_data (lsbData), .tx_busy (tx_busy), .idle (lsbIdle)
    );

    // Transmitter model: busy for 10 cycles starting the cycle after a strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) busyLeft <= 0;
        else if (tx_start) busyLeft <= 10;
        else if (busyLeft > 0) busyLeft <= busyLeft - 1;
    end
    assign tx_busy = holdBusy | (busyLeft > 0);

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start) begin
            msbQ.push_back(tx_data);
            strobeCyc.push_back(cycle);
            cntAtStrobe.push_back(int'(fifo_count));
            check("strobeWhileBusy", 32'(tx_busy), 0);
            check("strobeWidth", 32'(prevStart), 0);
        end
        if (lsbStart) lsbQ.push_back(lsbData);
        prevStart = tx_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearQ();
        msbQ.delete();
        lsbQ.delete();
        strobeCyc.delete();
        cntAtStrobe.delete();
    endtask

    task automatic doReset();
        sample_valid = 1'b0;
        sample_data  = '0;
        holdBusy     = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        clearQ();
    endtask

    task automatic push(input logic [15:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int maxCyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxCyc && !done; i++) begin
            tick();
            if (idle && lsbIdle && !tx_busy) done = 1'b1;
        end
        check(name, 32'(done), 1);
    endtask

    task automatic checkByte(input string name, input int k,
                             input logic [7:0] m, input logic [7:0] l);
        if (k < msbQ.size()) check(name, 32'(msbQ[k]), 32'(m));
        else check({name, "Missing"}, 32'(msbQ.size()), 32'(k + 1));
        if (k < lsbQ.size()) check({name, "Lsb"}, 32'(lsbQ[k]), 32'(l));
        else check({name, "LsbMissing"}, 32'(lsbQ.size()), 32'(k + 1));
    endtask

    typedef struct {
        int               n;
        logic [1:0][15:0] s;
        logic [3:0][7:0]  msb;
        logic [3:0][7:0]  lsb;
    } vec_t;

    vec_t tbl[3];

    initial begin
        tbl[0] = '{n: 1, s: {16'h0000, 16'hA55A},
                   msb: {8'h00, 8'h00, 8'h5A, 8'hA5},
                   lsb: {8'h00, 8'h00, 8'hA5, 8'h5A}};
        tbl[1] = '{n: 2, s: {16'h5678, 16'h1234},
                   msb: {8'h78, 8'h56, 8'h34, 8'h12},
                   lsb: {8'h56, 8'h78, 8'h12, 8'h34}};
        tbl[2] = '{n: 2, s: {16'h00FF, 16'hFF00},
                   msb: {8'hFF, 8'h00, 8'h00, 8'hFF},
                   lsb: {8'h00, 8'hFF, 8'hFF, 8'h00}};

        // Reset values and single-sample latency
        doReset();
        check("rstReady", 32'(sample_ready), 1);
        check("rstOverflow", 32'(overflow), 0);
        check("rstCount", 32'(fifo_count), 0);
        check("rstStart", 32'(tx_start), 0);
        check("rstData", 32'(tx_data), 0);
        check("rstIdle", 32'(idle), 1);
        push(16'hA55A);
        check("e0Count", 32'(fifo_count), 1);
        check("e0Start", 32'(tx_start), 0);
        check("e0Idle", 32'(idle), 0);
        tick();
        check("e1Start", 32'(tx_start), 1);
        check("e1Data", 32'(tx_data), 32'h A5);
        check("e1LsbData", 32'(lsbData), 32'h5A);
        check("e1Count", 32'(fifo_count), 0);
        tick();
        check("e2Start", 32'(tx_start), 0);
        check("e2Busy", 32'(tx_busy), 1);
        waitIdle("latIdle", 200);
        check("latStrobes", 32'(msbQ.size()), 2);
        checkByte("latByte0", 0, 8'hA5, 8'h5A);
        checkByte("latByte1", 1, 8'h5A, 8'hA5);
        if (strobeCyc.size() == 2)
            check("latGap", 32'(strobeCyc[1] - strobeCyc[0]), 12);
        check("latIdleEnd", 32'(idle), 1);

        // Table: buffered samples released at once
        for (int v = 0; v < 3; v++) begin
            doReset();
            holdBusy = 1'b1;
            for (int j = 0; j < tbl[v].n; j++) push(tbl[v].s[j]);
            check("tblCount", 32'(fifo_count), 32'(tbl[v].n));
            holdBusy = 1'b0;
            waitIdle("tblIdle", 400);
            check("tblStrobes", 32'(msbQ.size()), 32'(2 * tbl[v].n));
            for (int k = 0; k < 2 * tbl[v].n; k++) begin
                checkByte("tblByte", k, tbl[v].msb[k], tbl[v].lsb[k]);
                if (k < cntAtStrobe.size())
                    check("tblCntAtStrobe", 32'(cntAtStrobe[k]),
                          32'(tbl[v].n - 1 - k / 2));
                if (k > 0 && k < strobeCyc.size())
                    check("tblGap", 32'(strobeCyc[k] - strobeCyc[k-1]), 12);
            end
        end

        // Overflow with transmitter held busy
        doReset();
        holdBusy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(16'h0100 + 16'(i));
            if (i == 7) begin
                check("ovfCount8", 32'(fifo_count), 8);
                check("ovfReady8", 32'(sample_ready), 0);
                check("ovfFlag8", 32'(overflow), 0);
            end
        end
        check("ovfFlag", 32'(overflow), 1);
        check("ovfCount", 32'(fifo_count), 8);
        check("ovfNoStrobe", 32'(msbQ.size()), 0);
        holdBusy = 1'b0;
        waitIdle("ovfIdle", 1000);
        check("ovfSticky", 32'(overflow), 1);
        check("ovfStrobes", 32'(msbQ.size()), 16);
        for (int k = 0; k < 16; k++)
            checkByte("ovfByte", k,
                      (k % 2 == 0) ? 8'h01 : 8'(k / 2),
                      (k % 2 == 0) ? 8'(k / 2) : 8'h01);

        // Busy when the first sample arrives
        doReset();
        holdBusy = 1'b1;
        push(16'hC3E1);
        tick();
        tick();
        check("bsyCount", 32'(fifo_count), 1);
        check("bsyNoStart", 32'(tx_start), 0);
        holdBusy = 1'b0;
        tick();
        check("bsyPopCount", 32'(fifo_count), 0);
        check("bsyStart", 32'(tx_start), 1);
        check("bsyData", 32'(tx_data), 32'hC3);
        waitIdle("bsyIdle", 200);
        checkByte("bsyByte0", 0, 8'hC3, 8'hE1);
        checkByte("bsyByte1", 1, 8'hE1, 8'hC3);

        // Reset while the strobe is high
        doReset();
        push(16'h7E7E);
        tick();
        check("rsStrobe", 32'(tx_start), 1);
        rst = 1'b1;
        #1;
        check("rsStartDrop", 32'(tx_start), 0);
        tick();
        rst = 1'b0;

        // Reset in WAIT with three samples buffered
        doReset();
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        tick();
        check("rwCount", 32'(fifo_count), 3);
        rst = 1'b1;
        #1;
        check("rwStart", 32'(tx_start), 0);
        check("rwCountClr", 32'(fifo_count), 0);
        check("rwIdle", 32'(idle), 1);
        check("rwReady", 32'(sample_ready), 1);
        clearQ();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("rwQuiet", 32'(msbQ.size()), 0);
        push(16'hBEEF);
        waitIdle("rwIdleEnd", 200);
        check("rwStrobes", 32'(msbQ.size()), 2);
        checkByte("rwByte0", 0, 8'hBE, 8'hEF);
        checkByte("rwByte1", 1, 8'hEF, 8'hBE);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL globalTimeout: simulation did not finish");
        $fatal(1);
    end

endmodule
